// File: rtl/bsmt_io_pkg.sv
// Shared port map, status bit positions and sample-pair type for the
// BSMT2000 DSP port responder.
package bsmt_io_pkg;

   localparam logic [2:0] PORT_ADDR_LO = 3'd0;
   localparam logic [2:0] PORT_ADDR_HI = 3'd1;
   localparam logic [2:0] PORT_ROM     = 3'd2;
   localparam logic [2:0] PORT_LEFT    = 3'd3;
   localparam logic [2:0] PORT_RIGHT   = 3'd7;
   localparam logic [2:0] PORT_STATUS  = 3'd0;
   localparam logic [2:0] PORT_CMD     = 3'd1;

   localparam int STAT_PENDING  = 0;
   localparam int STAT_NOT_FULL = 1;
   localparam int STAT_OVERRUN  = 2;
   localparam int STAT_OVERFLOW = 3;

   typedef struct packed {
      logic [15:0] left;
      logic [15:0] right;
   } pair_t;

   function automatic logic [15:0] status_word(input logic pending,
                                               input logic not_full,
                                               input logic overrun,
                                               input logic overflow);
      logic [15:0] w;
      w                = 16'h0000;
      w[STAT_PENDING]  = pending;
      w[STAT_NOT_FULL] = not_full;
      w[STAT_OVERRUN]  = overrun;
      w[STAT_OVERFLOW] = overflow;
      return w;
   endfunction

endpackage

// File: rtl/bsmt_sample_fifo.sv
// Stereo-pair sample FIFO. A push into a full FIFO is accepted only when a
// pop frees the head slot in the same cycle; a pop never bypasses a push.
module bsmt_sample_fifo
   import bsmt_io_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  push_i,
   input  pair_t push_data_i,
   input  logic  pop_i,
   output pair_t head_o,
   output logic  full_o,
   output logic  empty_o,
   output logic  drop_o
);

   localparam int AW = $clog2(DEPTH);

   pair_t          mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           push_ok, pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign drop_o  = push_i & ~push_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy alone defines what is valid.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/bsmt_port_responder.sv
// DSP port-side responder: ROM address latch/read port, host command
// mailbox, status word and stereo sample FIFO feeding the audio mixer.
module bsmt_port_responder
   import bsmt_io_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE_R,
   input  logic [2:0]  A,
   input  logic [15:0] DSP_DO,
   input  logic        WE_N,
   input  logic        DEN_N,
   output logic [15:0] DSP_DI,
   output logic [20:1] ROM_A,
   input  logic [15:0] ROM_DO,
   input  logic        HOST_WR,
   input  logic [15:0] HOST_DI,
   output logic        HOST_BUSY,
   input  logic        SAMPLE_CE,
   output logic [15:0] AUD_L,
   output logic [15:0] AUD_R
);

   logic        wr_acc, rd_acc, rd_cmd, rd_stat, push;
   logic [19:0] rom_a_q, rom_a_d;
   logic [15:0] left_q, left_d;
   logic [15:0] cmd_q, cmd_d;
   logic        pending_q, pending_d;
   logic        ovr_q, ovr_d, ovf_q, ovf_d;
   logic [15:0] aud_l_q, aud_l_d, aud_r_q, aud_r_d;
   pair_t       push_pair, head;
   logic        fifo_full, fifo_empty, fifo_drop, pop_fire;

   assign wr_acc  = ~WE_N & CE_R;
   assign rd_acc  = ~DEN_N & CE_R;
   assign rd_cmd  = rd_acc & (A == PORT_CMD);
   assign rd_stat = rd_acc & (A == PORT_STATUS);
   assign push    = wr_acc & (A == PORT_RIGHT);
   assign pop_fire = SAMPLE_CE & ~fifo_empty;

   assign push_pair.left  = left_q;
   assign push_pair.right = DSP_DO;

   bsmt_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i       (CLK),
      .rst_i       (RST),
      .push_i      (push),
      .push_data_i (push_pair),
      .pop_i       (SAMPLE_CE),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .drop_o      (fifo_drop)
   );

   always_comb begin
      rom_a_d = rom_a_q;
      left_d  = left_q;
      if (wr_acc) begin
         case (A)
            PORT_ADDR_LO: rom_a_d[15:0]  = DSP_DO;
            PORT_ADDR_HI: rom_a_d[19:16] = DSP_DO[3:0];
            PORT_LEFT:    left_d         = DSP_DO;
            default:      ;
         endcase
      end
   end

   // A host write racing a DSP command read hands the DSP the old word and
   // leaves the new one pending, so it is not an overrun. Sticky set beats clear.
   always_comb begin
      cmd_d     = HOST_WR ? HOST_DI : cmd_q;
      pending_d = HOST_WR | (pending_q & ~rd_cmd);
      ovr_d     = (HOST_WR & pending_q & ~rd_cmd) | (ovr_q & ~rd_stat);
      ovf_d     = fifo_drop | (ovf_q & ~rd_stat);
      aud_l_d   = pop_fire ? head.left  : aud_l_q;
      aud_r_d   = pop_fire ? head.right : aud_r_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rom_a_q   <= '0;
         left_q    <= '0;
         cmd_q     <= '0;
         pending_q <= 1'b0;
         ovr_q     <= 1'b0;
         ovf_q     <= 1'b0;
         aud_l_q   <= '0;
         aud_r_q   <= '0;
      end else begin
         rom_a_q   <= rom_a_d;
         left_q    <= left_d;
         cmd_q     <= cmd_d;
         pending_q <= pending_d;
         ovr_q     <= ovr_d;
         ovf_q     <= ovf_d;
         aud_l_q   <= aud_l_d;
         aud_r_q   <= aud_r_d;
      end
   end

   always_comb begin
      DSP_DI = 16'h0000;
      case (A)
         PORT_STATUS: DSP_DI = status_word(pending_q, ~fifo_full, ovr_q, ovf_q);
         PORT_CMD:    DSP_DI = cmd_q;
         PORT_ROM:    DSP_DI = ROM_DO;
         default:     DSP_DI = 16'h0000;
      endcase
   end

   assign ROM_A     = rom_a_q;
   assign HOST_BUSY = pending_q;
   assign AUD_L     = aud_l_q;
   assign AUD_R     = aud_r_q;

endmodule

// File: tb/tb_bsmt_port_responder.sv
// Directed plus randomized bench for bsmt_port_responder with a
// transaction-level model (queue FIFO, flag variables, ROM function).
module tb_bsmt_port_responder;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        CE_R = 1'b0;
   logic [2:0]  A = 3'd0;
   logic [15:0] DSP_DO = 16'h0;
   logic        WE_N = 1'b1;
   logic        DEN_N = 1'b1;
   logic [15:0] DSP_DI;
   logic [20:1] ROM_A;
   logic [15:0] ROM_DO = 16'h0;
   logic        HOST_WR = 1'b0;
   logic [15:0] HOST_DI = 16'h0;
   logic        HOST_BUSY;
   logic        SAMPLE_CE = 1'b0;
   logic [15:0] AUD_L, AUD_R;

   int checks = 0;
   int errors = 0;

   bsmt_port_responder #(.FIFO_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .CE_R(CE_R), .A(A), .DSP_DO(DSP_DO),
      .WE_N(WE_N), .DEN_N(DEN_N), .DSP_DI(DSP_DI), .ROM_A(ROM_A),
      .ROM_DO(ROM_DO), .HOST_WR(HOST_WR), .HOST_DI(HOST_DI),
      .HOST_BUSY(HOST_BUSY), .SAMPLE_CE(SAMPLE_CE), .AUD_L(AUD_L), .AUD_R(AUD_R)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] rom_f(input logic [19:0] x);
      return x[15:0] ^ {x[19:16], x[19:16], 8'hC3};
   endfunction

   // Synchronous sample ROM with one-cycle latency.
   always @(posedge CLK) ROM_DO <= rom_f(ROM_A);

   // Reference model state
   logic [19:0] m_rom_a;
   logic [15:0] m_left, m_cmd, m_aud_l, m_aud_r;
   logic        m_pend, m_ovr, m_ovf;
   logic [31:0] m_q[$];
   int          m_age;

   task automatic model_reset();
      m_rom_a = '0; m_left = '0; m_cmd = '0; m_aud_l = '0; m_aud_r = '0;
      m_pend = 0; m_ovr = 0; m_ovf = 0; m_q.delete(); m_age = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_read(input logic [2:0] a, output logic [15:0] v, output logic ok);
      ok = 1'b1;
      case (a)
         3'd0: v = {12'h000, m_ovf, m_ovr, (m_q.size() < DEPTH), m_pend};
         3'd1: v = m_cmd;
         3'd2: begin v = rom_f(m_rom_a); ok = (m_age >= 2); end
         default: v = 16'h0000;
      endcase
   endtask

   task automatic model_update(input logic [2:0] a, input logic we, input logic rd,
                               input logic [15:0] d, input logic hw, input logic [15:0] hd,
                               input logic sce, input logic ce);
      logic wr, rv, rd_cmd, rd_stat, popped, drop;
      wr = we & ce; rv = rd & ce;
      rd_cmd = rv && a == 3'd1; rd_stat = rv && a == 3'd0;
      m_age++;
      popped = 0; drop = 0;
      if (sce && m_q.size() > 0) begin
         {m_aud_l, m_aud_r} = m_q.pop_front();
         popped = 1;
      end
      if (wr) begin
         if (a == 3'd0) begin m_rom_a[15:0] = d; m_age = 0; end
         if (a == 3'd1) begin m_rom_a[19:16] = d[3:0]; m_age = 0; end
         if (a == 3'd7) begin
            if (m_q.size() >= DEPTH) drop = 1;
            else m_q.push_back({m_left, d});
         end
         if (a == 3'd3) m_left = d;
      end
      m_ovr = (hw && m_pend && !rd_cmd) ? 1'b1 : (rd_stat ? 1'b0 : m_ovr);
      m_ovf = drop ? 1'b1 : (rd_stat ? 1'b0 : m_ovf);
      m_pend = hw ? 1'b1 : (rd_cmd ? 1'b0 : m_pend);
      if (hw) m_cmd = hd;
   endtask

   task automatic step(input logic [2:0] a, input logic we, input logic rd, input logic [15:0] d,
                       input logic hw, input logic [15:0] hd, input logic sce, input logic ce);
      logic [15:0] exp_di;
      logic        ok;
      A = a; WE_N = ~we; DEN_N = ~rd; DSP_DO = d; HOST_WR = hw; HOST_DI = hd;
      SAMPLE_CE = sce; CE_R = ce;
      #1;
      model_read(a, exp_di, ok);
      if (ok) check("dsp_di", {16'h0, DSP_DI}, {16'h0, exp_di});
      @(posedge CLK); #1;
      model_update(a, we, rd, d, hw, hd, sce, ce);
      check("rom_a", {12'h0, ROM_A}, {12'h0, m_rom_a});
      check("host_busy", {31'h0, HOST_BUSY}, {31'h0, m_pend});
      check("aud", {AUD_L, AUD_R}, {m_aud_l, m_aud_r});
      WE_N = 1'b1; DEN_N = 1'b1; HOST_WR = 1'b0; SAMPLE_CE = 1'b0;
   endtask

   task automatic idle();
      step(3'd4, 0, 0, 16'h0, 0, 16'h0, 0, 1);
   endtask

   task automatic peek_status(input logic [15:0] exp, input string tag);
      A = 3'd0; #1;
      check(tag, {16'h0, DSP_DI}, {16'h0, exp});
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      CE_R = 1'b1;

      // Reset state
      peek_status(16'h0002, "reset_status");
      check("reset_aud", {AUD_L, AUD_R}, 32'h0);
      check("reset_busy", {31'h0, HOST_BUSY}, 32'h0);
      check("reset_rom_a", {12'h0, ROM_A}, 32'h0);

      // ROM address latch and read port
      step(3'd0, 1, 0, 16'h1234, 0, 0, 0, 1);
      step(3'd1, 1, 0, 16'h0005, 0, 0, 0, 1);
      check("rom_a_51234", {12'h0, ROM_A}, 32'h51234);
      idle(); idle();
      step(3'd2, 0, 1, 16'h0, 0, 0, 0, 1);

      // Host mailbox
      step(3'd4, 0, 0, 0, 1, 16'hA5A5, 0, 1);
      check("busy_after_hw", {31'h0, HOST_BUSY}, 32'h1);
      peek_status(16'h0003, "status_pending");
      step(3'd1, 0, 1, 0, 0, 0, 0, 1);
      check("busy_after_read", {31'h0, HOST_BUSY}, 32'h0);
      step(3'd4, 0, 0, 0, 1, 16'h1111, 0, 1);
      step(3'd4, 0, 0, 0, 1, 16'h2222, 0, 1);
      peek_status(16'h0007, "status_overrun");
      step(3'd0, 0, 1, 0, 0, 0, 0, 1);
      peek_status(16'h0003, "status_ovr_cleared");
      // Host write racing a command read: old value, still pending, no overrun
      step(3'd1, 0, 1, 0, 1, 16'h3333, 0, 1);
      peek_status(16'h0003, "race_cmd_read");
      // Host write overrun coinciding with a status read: set wins
      step(3'd0, 0, 1, 0, 1, 16'h4444, 0, 1);
      peek_status(16'h0007, "set_beats_clear");
      step(3'd0, 0, 1, 0, 0, 0, 0, 1);
      step(3'd1, 0, 1, 0, 0, 0, 0, 1);

      // FIFO fill, overflow, drain
      for (int i = 1; i <= 5; i++) begin
         step(3'd3, 1, 0, 16'(i), 0, 0, 0, 1);
         step(3'd7, 1, 0, 16'h8000 | 16'(i), 0, 0, 0, 1);
      end
      peek_status(16'h0008, "status_overflow");
      step(3'd0, 0, 1, 0, 0, 0, 0, 1);
      for (int i = 1; i <= 5; i++) begin
         step(3'd4, 0, 0, 0, 0, 0, 1, 1);
         check("drain", {AUD_L, AUD_R}, {16'(i > 4 ? 4 : i), 16'h8000 | 16'(i > 4 ? 4 : i)});
      end

      // Push and pop on a full FIFO
      for (int i = 0; i < 4; i++) begin
         step(3'd3, 1, 0, 16'h0010 + 16'(i), 0, 0, 0, 1);
         step(3'd7, 1, 0, 16'h9010 + 16'(i), 0, 0, 0, 1);
      end
      step(3'd3, 1, 0, 16'h0020, 0, 0, 0, 1);
      step(3'd7, 1, 0, 16'h9020, 0, 0, 1, 1);
      check("full_pushpop_head", {AUD_L, AUD_R}, 32'h0010_9010);
      peek_status(16'h0000, "full_pushpop_status");
      repeat (4) step(3'd4, 0, 0, 0, 0, 0, 1, 1);
      check("full_pushpop_tail", {AUD_L, AUD_R}, 32'h0020_9020);

      // Push and pop on an empty FIFO: no bypass
      step(3'd3, 1, 0, 16'h0030, 0, 0, 0, 1);
      step(3'd7, 1, 0, 16'h9030, 0, 0, 1, 1);
      check("empty_pushpop_hold", {AUD_L, AUD_R}, 32'h0020_9020);
      step(3'd4, 0, 0, 0, 0, 0, 1, 1);
      check("empty_pushpop_pop", {AUD_L, AUD_R}, 32'h0030_9030);

      // Writes without CE_R are ignored
      step(3'd0, 1, 0, 16'hFFFF, 0, 0, 0, 0);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) begin
         step(3'd3, 1, 0, 16'h0040 + 16'(i), 0, 0, 0, 1);
         step(3'd7, 1, 0, 16'h9040 + 16'(i), 0, 0, 0, 1);
      end
      step(3'd4, 0, 0, 0, 1, 16'h5555, 1, 1);
      A = 3'd0;
      #2 RST = 1'b1;
      #1;
      check("rst_aud", {AUD_L, AUD_R}, 32'h0);
      check("rst_busy", {31'h0, HOST_BUSY}, 32'h0);
      check("rst_rom_a", {12'h0, ROM_A}, 32'h0);
      check("rst_status", {16'h0, DSP_DI}, 32'h0002);
      model_reset();
      @(posedge CLK); #3 RST = 1'b0;
      @(posedge CLK); #1;
      peek_status(16'h0002, "post_rst_status");

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [2:0] a;
         logic we, rd, hw, sce, ce;
         a   = 3'($urandom_range(0, 7));
         we  = ($urandom_range(0, 2) == 0);
         rd  = ($urandom_range(0, 2) == 0);
         hw  = ($urandom_range(0, 7) == 0);
         sce = ($urandom_range(0, 3) == 0);
         ce  = ($urandom_range(0, 7) != 0);
         step(a, we, rd, 16'($urandom), hw, 16'($urandom), sce, ce);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
